mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
- Parametrised successor to the basic n-bit clear-only counter.
- Adds programmable modulus, up/down direction, count enable and synchronous parallel load.
- Adds a combinational terminal-count output for cascading and a registered wrap pulse.
- Used as a general timebase or event counter; instances chain through tc to form multi-digit counters.

Parameters:
- n, 8, counter width in bits (n >= 2).
- MAX, 2**n-1, highest count value. Legal range 1..2**n-1. Count sequence is 0..MAX.

Ports:
- clock  input  1  rising-edge clock.
- clear  input  1  synchronous active-high reset.
- enable  input  1  count enable; q advances one step per enabled cycle.
- up_down  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_value  input  n  value loaded when load=1.
- q  output  n  current count (registered).
- tc  output  1  terminal count (combinational).
- wrap  output  1  registered one-cycle pulse after each wrap.

Behaviour:
- Reset: clear=1 at a rising edge sets q=0 and wrap=0 on that edge. tc follows the tc equation with q=0.
- Priority per edge: clear > load > enable > hold.
- Load:
  - load=1 and clear=0: q <= load_value if load_value <= MAX, else q <= MAX (clamp).
  - wrap <= 0 on a load cycle.
  - load overrides enable in the same cycle.
- Count up (enable=1, up_down=1):
  - q < MAX: q <= q+1.
  - q == MAX: q <= 0 and wrap <= 1.
- Count down (enable=1, up_down=0):
  - q > 0: q <= q-1.
  - q == 0: q <= MAX and wrap <= 1.
- Hold: enable=0 leaves q unchanged and sets wrap <= 0.
- wrap is high for exactly the one cycle following the wrapping edge; otherwise 0.
- tc = enable & ((up_down & q==MAX) | (~up_down & q==0)).
  - Purely combinational from current inputs and q.
  - Drives the enable of the next cascaded stage.
  - load and clear do not gate tc.
- Out-of-range q cannot occur: load clamps, and counting never exceeds MAX.
- Direction change takes effect on the next enabled edge. No extra latency.
- Latency: q changes on the same rising edge that samples enable/load/clear. wrap lags the wrapping edge by zero cycles, i.e. it is set by that edge.
- clear asserted mid-count, or in the same cycle as load or wrap: clear wins. q=0, wrap=0.
- Arithmetic stays in n bits with no overflow, since MAX <= 2**n-1 and wrap is explicit.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined: the counter saturates instead of wrapping.
  - Up at q==MAX holds at MAX; down at q==0 holds at 0.
  - wrap is replaced by a registered sticky flag. It is set when a saturating step is attempted and cleared only by clear or load.
  - Port name wrap is kept.
  - tc behaviour is unchanged.
- Undefined: modulo wrap-around as described in Behaviour.

Test Plan (n=4, MAX=9 unless stated):
1. clear=1 for 2 cycles, then clear=0, enable=1, up_down=1 for 12 cycles -> q = 0,1,...,9,0,1,2. tc=1 only while q=9. wrap=1 for exactly the cycle where q=0 after 9.
2. load=1, load_value=3, then enable=1, up_down=0 for 5 cycles -> q = 3,2,1,0,9,8. tc=1 while q=0. wrap pulses once when q becomes 9.
3. load=1, load_value=14 -> q=9 (clamped). Same cycle with enable=1 -> load still wins, q=9.
4. q=9, enable=1, up_down=1, clear=1 on the same edge -> q=0, wrap=0. Separately, enable=0 at q=5 for 4 cycles -> q holds at 5, tc=0.
5. Two instances cascaded (low stage tc drives high stage enable), MAX=9, count up 25 enabled cycles from 0 -> high=2, low=5. High stage increments only on the low stage's 9->0 edges.
6. With COUNTER_SATURATE_EN: count up 12 cycles from 0 -> q sticks at 9 and wrap stays 1 from the first saturating step. A load of 4 -> wrap=0, q=4.

Source files
------------

// File: rtl/mod_updown_counter.sv
// mod_updown_counter
//   n-bit up/down counter with programmable modulus (count sequence 0..MAX),
//   count enable, synchronous parallel load with clamping, a combinational
//   terminal-count output for cascading, and a registered wrap pulse.
//
//   Optional build macro COUNTER_SATURATE_EN:
//     undefined - modulo counting; wrap pulses for one cycle after each wrap.
//     defined   - the counter saturates at MAX (up) or 0 (down); wrap becomes
//                 a sticky flag that is set by any saturating step attempt and
//                 cleared only by clear or load.
//
// Parameters:
//   n    counter width in bits (n >= 2)
//   MAX  highest count value, 1 .. 2**n-1
//
// Ports:
//   clock       in   rising-edge clock
//   clear       in   synchronous active-high reset (q=0, wrap=0)
//   enable      in   count enable
//   up_down     in   1 = increment, 0 = decrement
//   load        in   parallel load strobe (overrides enable)
//   load_value  in   value to load, clamped to MAX
//   q           out  current count (registered)
//   tc          out  terminal count, combinational from enable/up_down/q
//   wrap        out  registered wrap pulse (sticky saturate flag if enabled)
module mod_updown_counter #(
  parameter int             n   = 8,
  parameter logic [n-1:0]   MAX = {n{1'b1}}
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         enable,
  input  logic         up_down,
  input  logic         load,
  input  logic [n-1:0] load_value,
  output logic [n-1:0] q,
  output logic         tc,
  output logic         wrap
);

  localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

  // Loaded values above MAX are clamped so q can never leave 0..MAX.
  function automatic logic [n-1:0] clamp_load(input logic [n-1:0] v);
    return (v > MAX) ? MAX : v;
  endfunction

  logic [n-1:0] q_p0;
  logic         wrap_p0;
  logic [n-1:0] q_next;
  logic         wrap_next;
  logic         at_max;
  logic         at_zero;

  assign at_max  = (q_p0 == MAX);
  assign at_zero = (q_p0 == '0);

  always_comb begin
    q_next = q_p0;
`ifdef COUNTER_SATURATE_EN
    // Sticky: survives hold and non-saturating steps.
    wrap_next = wrap_p0;
`else
    wrap_next = 1'b0;
`endif
    if (load) begin
      q_next    = clamp_load(load_value);
      wrap_next = 1'b0;
    end else if (enable) begin
      if (up_down) begin
        if (at_max) begin
`ifdef COUNTER_SATURATE_EN
          q_next = MAX;
`else
          q_next = '0;
`endif
          wrap_next = 1'b1;
        end else begin
          q_next = q_p0 + ONE;
        end
      end else begin
        if (at_zero) begin
`ifdef COUNTER_SATURATE_EN
          q_next = '0;
`else
          q_next = MAX;
`endif
          wrap_next = 1'b1;
        end else begin
          q_next = q_p0 - ONE;
        end
      end
    end
  end

  // Stage p0: count and wrap registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      q_p0    <= '0;
      wrap_p0 <= 1'b0;
    end else begin
      q_p0    <= q_next;
      wrap_p0 <= wrap_next;
    end
  end

  assign q    = q_p0;
  assign wrap = wrap_p0;

  // Not gated by load or clear so a cascade sees the pure count condition.
  assign tc = enable & ((up_down & at_max) | (~up_down & at_zero));

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

  localparam int N   = 4;
  localparam int MAX = 9;

  logic         clock;
  logic         clear;
  logic         enable;
  logic         up_down;
  logic         load;
  logic [N-1:0] load_value;
  logic [N-1:0] q;
  logic         tc;
  logic         wrap;

  // cascade pair
  logic         c_clear;
  logic         c_en;
  logic [N-1:0] lo_q, hi_q;
  logic         lo_tc, hi_tc, lo_wrap, hi_wrap;

  int vectors;
  int miscompares;

  // reference model state
  int m_q;
  bit m_wrap;

  mod_updown_counter #(.n(N), .MAX(4'd9)) dut (
    .clock(clock), .clear(clear), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .q(q), .tc(tc), .wrap(wrap)
  );

  mod_updown_counter #(.n(N), .MAX(4'd9)) u_lo (
    .clock(clock), .clear(c_clear), .enable(c_en), .up_down(1'b1),
    .load(1'b0), .load_value(4'd0), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
  );

  mod_updown_counter #(.n(N), .MAX(4'd9)) u_hi (
    .clock(clock), .clear(c_clear), .enable(lo_tc), .up_down(1'b1),
    .load(1'b0), .load_value(4'd0), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: treat the count as an integer, step by +/-1, then either reduce
  // modulo (MAX+1) or clip to [0,MAX]; an out-of-range step is a wrap event.
  task automatic model_edge();
    int t;
    if (clear) begin
      m_q = 0;
      m_wrap = 0;
    end else if (load) begin
      m_q = (int'(load_value) > MAX) ? MAX : int'(load_value);
      m_wrap = 0;
    end else if (enable) begin
      t = m_q + (up_down ? 1 : -1);
`ifdef COUNTER_SATURATE_EN
      if (t < 0 || t > MAX) m_wrap = 1;
      m_q = (t < 0) ? 0 : ((t > MAX) ? MAX : t);
`else
      m_wrap = (t < 0 || t > MAX);
      m_q = (t + MAX + 1) % (MAX + 1);
`endif
    end else begin
`ifndef COUNTER_SATURATE_EN
      m_wrap = 0;
`endif
    end
  endtask

  function automatic bit model_tc();
    return enable && ((up_down && m_q == MAX) || (!up_down && m_q == 0));
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    clear = 1; enable = 1; up_down = 1; load = 1; load_value = 4'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (q !== 4'd0 || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL reset: q=%0d wrap=%0b, required q=0 wrap=0", q, wrap);
      end
    end
    load = 0;
  endtask

  task automatic test_count_up();
    int eq;
    bit ew;
    clear = 0; load = 0; enable = 1; up_down = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      vectors++;
      if (tc !== model_tc()) begin
        miscompares++;
        $display("FAIL up_tc step %0d: tc=%0b required %0b (q=%0d)", i, tc, model_tc(), q);
      end
      tick();
`ifdef COUNTER_SATURATE_EN
      eq = (i + 1 > MAX) ? MAX : i + 1;
      ew = (i >= MAX);
`else
      eq = (i + 1) % (MAX + 1);
      ew = (i == MAX);
`endif
      vectors++;
      if (q !== eq[N-1:0] || wrap !== ew || m_q != eq) begin
        miscompares++;
        $display("FAIL up_seq step %0d: q=%0d wrap=%0b required q=%0d wrap=%0b", i, q, wrap, eq, ew);
      end
    end
    // a load always clears the wrap/sticky flag
    load = 1; load_value = 4'd4;
    tick();
    vectors++;
    if (q !== 4'd4 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL load4: q=%0d wrap=%0b required q=4 wrap=0", q, wrap);
    end
    load = 0;
  endtask

  task automatic test_count_down();
    int exp_seq [5];
    bit exp_w [5];
`ifdef COUNTER_SATURATE_EN
    exp_seq = '{2, 1, 0, 0, 0};
    exp_w   = '{0, 0, 0, 1, 1};
`else
    exp_seq = '{2, 1, 0, 9, 8};
    exp_w   = '{0, 0, 0, 1, 0};
`endif
    clear = 0; enable = 0; load = 1; load_value = 4'd3;
    tick();
    vectors++;
    if (q !== 4'd3) begin
      miscompares++;
      $display("FAIL down_load: q=%0d required 3", q);
    end
    load = 0; enable = 1; up_down = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (tc !== model_tc()) begin
        miscompares++;
        $display("FAIL down_tc step %0d: tc=%0b required %0b", i, tc, model_tc());
      end
      tick();
      vectors++;
      if (q !== exp_seq[i][N-1:0] || wrap !== exp_w[i]) begin
        miscompares++;
        $display("FAIL down_seq step %0d: q=%0d wrap=%0b required q=%0d wrap=%0b",
                 i, q, wrap, exp_seq[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_load_clamp();
    clear = 0; enable = 0; load = 1; load_value = 4'd14;
    tick();
    vectors++;
    if (q !== 4'd9 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp: q=%0d wrap=%0b required q=9 wrap=0", q, wrap);
    end
    // load beats enable
    load_value = 4'd2; enable = 1; up_down = 1;
    tick();
    vectors++;
    if (q !== 4'd2) begin
      miscompares++;
      $display("FAIL load_over_enable: q=%0d required 2", q);
    end
    load_value = 4'd15;
    tick();
    vectors++;
    if (q !== 4'd9) begin
      miscompares++;
      $display("FAIL clamp15: q=%0d required 9", q);
    end
    load = 0;
  endtask

  task automatic test_clear_priority();
    load = 1; load_value = 4'd9; enable = 0; clear = 0;
    tick();
    load = 1; load_value = 4'd3; enable = 1; up_down = 1; clear = 1;
    tick();
    vectors++;
    if (q !== 4'd0 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_priority: q=%0d wrap=%0b required q=0 wrap=0", q, wrap);
    end
    clear = 0; load = 0;
  endtask

  task automatic test_hold();
    load = 1; load_value = 4'd5; enable = 0;
    tick();
    load = 0; up_down = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (tc !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_tc cycle %0d: tc=%0b required 0", i, tc);
      end
      tick();
      vectors++;
      if (q !== 4'd5 || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL hold cycle %0d: q=%0d wrap=%0b required q=5 wrap=0", i, q, wrap);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear      = ($urandom_range(0, 31) == 0);
      load       = ($urandom_range(0, 7) == 0);
      enable     = ($urandom_range(0, 3) != 0);
      up_down    = $urandom_range(0, 1);
      load_value = 4'($urandom_range(0, 15));
      #1;
      vectors++;
      if (tc !== model_tc()) begin
        miscompares++;
        $display("FAIL rand_tc %0d: tc=%0b required %0b", i, tc, model_tc());
      end
      tick();
      vectors++;
      if (q !== m_q[N-1:0] || wrap !== m_wrap) begin
        miscompares++;
        $display("FAIL rand %0d: q=%0d wrap=%0b required q=%0d wrap=%0b", i, q, wrap, m_q, m_wrap);
      end
    end
    clear = 0; load = 0; enable = 0;
  endtask

  task automatic test_cascade();
    int elo, ehi;
    c_clear = 1; c_en = 0;
    @(posedge clock); #1;
    c_clear = 0; c_en = 1;
    for (int t = 1; t <= 25; t++) begin
      @(posedge clock); #1;
`ifdef COUNTER_SATURATE_EN
      elo = (t > MAX) ? MAX : t;
      ehi = (t - MAX < 0) ? 0 : ((t - MAX > MAX) ? MAX : t - MAX);
`else
      elo = t % (MAX + 1);
      ehi = (t / (MAX + 1)) % (MAX + 1);
`endif
      vectors++;
      if (lo_q !== elo[N-1:0] || hi_q !== ehi[N-1:0]) begin
        miscompares++;
        $display("FAIL cascade t=%0d: hi=%0d lo=%0d required hi=%0d lo=%0d", t, hi_q, lo_q, ehi, elo);
      end
    end
    c_en = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_q = 0; m_wrap = 0;
    clear = 1; enable = 0; up_down = 1; load = 0; load_value = '0;
    c_clear = 1; c_en = 0;
    #2;
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clamp();
    test_clear_priority();
    test_hold();
    test_random();
    test_cascade();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
